// File: rtl/vga_capture.sv
// VGA sink: rebuilds pixel coordinates from vsync/blank_n edges, emits framebuffer writes
// and checks line/frame geometry. Define VGA_CAPTURE_CHECKSUM_EN to add a per-frame data checksum.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [9:0]  wr_x,
  output logic [9:0]  wr_y,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
`ifdef VGA_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0] frame_sum
`endif
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  typedef enum logic {WAIT_FRAME = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      r_state, w_state_nx;
  logic        r_hs_unused, r_vs, r_bn, r_vs_d, r_bn_d;
  logic [23:0] r_rgb;
  logic [9:0]  r_x, r_y, w_x_nx, w_y_nx, w_x_upd, w_y_upd;
  logic        w_vs, w_pix, w_eol, w_eol_ok;
  logic        w_write, w_done, w_err;

  logic        r_wr_en, r_frame_done, r_locked, r_err_pulse;
  logic [9:0]  r_wr_x, r_wr_y;
  logic [23:0] r_wr_data;
  logic [7:0]  r_err_count;
  logic [15:0] r_frame_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs_unused <= ~SYNC_ACTIVE;
      r_vs        <= ~SYNC_ACTIVE;
      r_vs_d      <= ~SYNC_ACTIVE;
      r_bn        <= 1'b0;
      r_bn_d      <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_hs_unused <= vga_hsync;
      r_vs        <= vga_vsync;
      r_vs_d      <= r_vs;
      r_bn        <= vga_blank_n;
      r_bn_d      <= r_bn;
      r_rgb       <= {vga_r, vga_g, vga_b};
    end
  end

  assign w_vs     = (r_vs == SYNC_ACTIVE) && (r_vs_d != SYNC_ACTIVE);
  assign w_pix    = r_bn;
  assign w_eol    = r_bn_d && !r_bn;
  assign w_eol_ok = w_eol && (r_x == H_LIM);
  // Coordinates after a completed line; the vsync check looks at these when both coincide.
  assign w_x_upd  = w_eol_ok ? 10'd0 : r_x;
  assign w_y_upd  = w_eol_ok ? r_y + 10'd1 : r_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= WAIT_FRAME;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_write = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (r_state == ACTIVE) begin
      if (w_pix) begin
        if (!w_vs && (r_x < H_LIM) && (r_y < V_LIM)) w_write = 1'b1;
        else                                         w_err   = 1'b1;
      end else if (w_vs) begin
        if ((!w_eol || w_eol_ok) && (w_y_upd == V_LIM) && (w_x_upd == 10'd0)) w_done = 1'b1;
        else                                                                 w_err  = 1'b1;
      end else if (w_eol && !w_eol_ok) begin
        w_err = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    case (r_state)
      WAIT_FRAME: begin
        if (w_vs) begin
          w_state_nx = ACTIVE;
          w_x_nx     = '0;
          w_y_nx     = '0;
        end
      end
      ACTIVE: begin
        if (w_vs) begin
          w_x_nx = '0;
          w_y_nx = '0;
        end else if (w_err) begin
          w_state_nx = WAIT_FRAME;
        end else if (w_write) begin
          w_x_nx = r_x + 10'd1;
        end else if (w_eol_ok) begin
          w_x_nx = w_x_upd;
          w_y_nx = w_y_upd;
        end
      end
      default: w_state_nx = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_en       <= 1'b0;
      r_wr_x        <= '0;
      r_wr_y        <= '0;
      r_wr_data     <= '0;
      r_frame_done  <= 1'b0;
      r_locked      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_count   <= '0;
      r_frame_count <= '0;
    end else begin
      r_wr_en      <= w_write;
      r_frame_done <= w_done;
      r_err_pulse  <= w_err;
      if (w_write) begin
        r_wr_x    <= r_x;
        r_wr_y    <= r_y;
        r_wr_data <= r_rgb;
      end
      if (w_err) begin
        r_locked <= 1'b0;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end else if (w_done) begin
        r_locked      <= 1'b1;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] r_acc, r_frame_sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc       <= '0;
      r_frame_sum <= '0;
    end else if (w_err) begin
      r_acc <= '0;
    end else if (w_done) begin
      r_frame_sum <= r_acc;
      r_acc       <= '0;
    end else if (w_write) begin
      r_acc <= r_acc + {8'd0, r_rgb};
    end
  end

  assign frame_sum = r_frame_sum;
`endif

  assign wr_en       = r_wr_en;
  assign wr_x        = r_wr_x;
  assign wr_y        = r_wr_y;
  assign wr_data     = r_wr_data;
  assign frame_done  = r_frame_done;
  assign locked      = r_locked;
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on an 8x4 geometry: a frame-level reference model predicts every
// cycle's outputs, and hand-computed totals pin both the model and the design.
module tb_vga_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam bit SA = 1'b0;

  logic        clock, reset;
  logic        vga_hsync, vga_vsync, vga_blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        wr_en, frame_done, locked, err_pulse;
  logic [9:0]  wr_x, wr_y;
  logic [23:0] wr_data;
  logic [7:0]  err_count;
  logic [15:0] frame_count;
`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE(SA)) dut (
    .clock(clock), .reset(reset),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .frame_count(frame_count)
`ifdef VGA_CAPTURE_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs per clock edge, produced by the frame model
  typedef struct {
    bit          rst;
    bit          wr;
    int          x;
    int          y;
    logic [23:0] d;
    bit          done;
    bit          lock;
    bit          err;
    int          ec;
    int          fc;
    logic [31:0] fs;
  } exp_t;

  exp_t exp_a [int];
  exp_t cur;
  int   edge_no = 0;

  bit          m_cap, m_prev_vs, m_prev_bn, m_lock;
  int          m_x, m_y, m_ec, m_fc;
  logic [31:0] m_sum, m_fs;

  task automatic model_reset();
    m_cap = 0; m_prev_vs = 0; m_prev_bn = 0; m_lock = 0;
    m_x = 0; m_y = 0; m_ec = 0; m_fc = 0; m_sum = '0; m_fs = '0;
  endtask

  // One input vector, sampled at edge e; its effect is visible after edge e+1.
  task automatic model(input int e, input bit rst, input bit vs_on, input bit bn, input logic [23:0] rgb);
    exp_t r;
    bit   vs_edge, eol, wr, done, err, line_bad;
    r = '{default: '0};
    if (rst) begin
      model_reset();
      r.rst = 1;
      exp_a[e] = r;
      r.rst = 0;
      exp_a[e+1] = r;
      return;
    end
    vs_edge = vs_on && !m_prev_vs;
    eol     = !bn && m_prev_bn;
    m_prev_vs = vs_on;
    m_prev_bn = bn;
    wr = 0; done = 0; err = 0; line_bad = 0;
    if (!m_cap) begin
      if (vs_edge) begin m_cap = 1; m_x = 0; m_y = 0; end
    end else if (vs_edge) begin
      if (eol) begin
        if (m_x == H) begin m_y++; m_x = 0; end
        else line_bad = 1;
      end
      if (!bn && !line_bad && m_y == V && m_x == 0) done = 1;
      else err = 1;
      m_x = 0; m_y = 0;
    end else if (bn) begin
      if (m_x < H && m_y < V) begin
        wr = 1; r.x = m_x; r.y = m_y; r.d = rgb; m_x++;
      end else begin
        err = 1; m_cap = 0;
      end
    end else if (eol) begin
      if (m_x == H) begin m_y++; m_x = 0; end
      else begin err = 1; m_cap = 0; end
    end
    if (err) begin
      m_lock = 0;
      if (m_ec < 255) m_ec++;
      m_sum = '0;
    end else if (done) begin
      m_lock = 1;
      m_fc = (m_fc + 1) % 65536;
      m_fs = m_sum;
      m_sum = '0;
    end
    if (wr) m_sum = m_sum + {8'd0, rgb};
    r.wr = wr; r.done = done; r.err = err; r.lock = m_lock;
    r.ec = m_ec; r.fc = m_fc; r.fs = m_fs;
    exp_a[e+1] = r;
  endtask

  always @(posedge clock) edge_no++;

  always @(negedge clock) begin
    if (exp_a.exists(edge_no)) begin
      cur = exp_a[edge_no];
      check("wr_en", 64'(wr_en), 64'(cur.wr));
      check("frame_done", 64'(frame_done), 64'(cur.done));
      check("err_pulse", 64'(err_pulse), 64'(cur.err));
      check("locked", 64'(locked), 64'(cur.lock));
      check("err_count", 64'(err_count), 64'(cur.ec));
      check("frame_count", 64'(frame_count), 64'(cur.fc));
      if (cur.wr || cur.rst) begin
        check("wr_x", 64'(wr_x), 64'(cur.x));
        check("wr_y", 64'(wr_y), 64'(cur.y));
        check("wr_data", 64'(wr_data), 64'(cur.d));
      end
`ifdef VGA_CAPTURE_CHECKSUM_EN
      check("frame_sum", 64'(frame_sum), 64'(cur.fs));
`endif
      exp_a.delete(edge_no);
    end
  end

  // Observed totals for the hand-computed checks
  int          n_wr, n_done, n_err, first_x, first_y, last_x, last_y;
  logic [23:0] last_d;

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      if (n_wr == 0) begin first_x = int'(wr_x); first_y = int'(wr_y); end
      last_x = int'(wr_x); last_y = int'(wr_y); last_d = wr_data;
      n_wr++;
    end
    if (frame_done === 1'b1) n_done++;
    if (err_pulse === 1'b1) n_err++;
  end

  task automatic clr();
    n_wr = 0; n_done = 0; n_err = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; last_d = '0;
  endtask

  task automatic cyc(input bit vs_on, input bit bn, input bit hs_on, input logic [23:0] rgb, input bit rst);
    reset       = rst;
    vga_vsync   = vs_on ? SA : ~SA;
    vga_hsync   = hs_on ? SA : ~SA;
    vga_blank_n = bn;
    {vga_r, vga_g, vga_b} = rgb;
    model(edge_no + 1, rst, vs_on, bn, rgb);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 24'h0, 0);
  endtask

  task automatic vs_pulse();
    cyc(1, 0, 0, 24'h0, 0);
    cyc(1, 0, 0, 24'h0, 0);
    idle(2);
  endtask

  function automatic logic [23:0] pix(input bit cst, input int c, input int r);
    return cst ? 24'hFF0000 : 24'(c + 8 * r);
  endfunction

  // Rows of active video; optionally one row of odd length, optionally vsync on the last line's blank edge
  task automatic rows(input int nrows, input int bad_row, input int bad_len, input bit cst, input bit eol_vs);
    for (int r = 0; r < nrows; r++) begin
      int len;
      len = (r == bad_row) ? bad_len : H;
      for (int c = 0; c < len; c++) cyc(0, 1, 0, pix(cst, c, r), 0);
      if (eol_vs && r == nrows - 1) begin
        cyc(1, 0, 0, 24'h0, 0);
        cyc(1, 0, 0, 24'h0, 0);
        idle(2);
      end else begin
        cyc(0, 0, 1, 24'h0, 0);
        cyc(0, 0, 0, 24'h0, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clr();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 24'h0, 1);
    idle(2);
    check("reset wr_en", 64'(wr_en), 64'd0);
    check("reset locked", 64'(locked), 64'd0);
    check("reset frame_count", 64'(frame_count), 64'd0);

    // Two clean frames of constant red
    clr();
    vs_pulse(); rows(V, -1, 0, 1, 0);
    vs_pulse(); rows(V, -1, 0, 1, 0);
    vs_pulse(); idle(2);
    check("nom writes", 64'(n_wr), 64'd64);
    check("nom first x", 64'(first_x), 64'd0);
    check("nom first y", 64'(first_y), 64'd0);
    check("nom last x", 64'(last_x), 64'd7);
    check("nom last y", 64'(last_y), 64'd3);
    check("nom last data", 64'(last_d), 64'hFF0000);
    check("nom frame_done pulses", 64'(n_done), 64'd2);
    check("nom locked", 64'(locked), 64'd1);
    check("nom frame_count", 64'(frame_count), 64'd2);
    check("nom err_count", 64'(err_count), 64'd0);

    // Short line: row 2 has 7 pixels
    clr();
    rows(V, 2, 7, 0, 0); idle(2);
    check("short writes", 64'(n_wr), 64'd23);
    check("short err pulses", 64'(n_err), 64'd1);
    check("short err_count", 64'(err_count), 64'd1);
    check("short locked", 64'(locked), 64'd0);
    vs_pulse(); rows(V, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("short recover locked", 64'(locked), 64'd1);
    check("short recover frame_count", 64'(frame_count), 64'd3);

    // Long line: row 0 has 9 pixels
    clr();
    rows(V, 0, 9, 0, 0); idle(2);
    check("long writes", 64'(n_wr), 64'd8);
    check("long err_count", 64'(err_count), 64'd2);
    check("long locked", 64'(locked), 64'd0);
    vs_pulse(); rows(V, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("long recover frame_count", 64'(frame_count), 64'd4);

    // Early vsync after 3 rows, then a full frame
    clr();
    rows(3, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("early frame_done pulses", 64'(n_done), 64'd0);
    check("early err_count", 64'(err_count), 64'd3);
    rows(V, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("early resync writes", 64'(n_wr), 64'd56);
    check("early resync frame_done", 64'(n_done), 64'd1);
    check("early resync frame_count", 64'(frame_count), 64'd5);

    // Vsync coinciding with the last blank edge, then a pattern frame
    clr();
    rows(V, -1, 0, 0, 1);
    check("eol+vs frame_count", 64'(frame_count), 64'd6);
    rows(V, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("eol+vs frame_done pulses", 64'(n_done), 64'd2);
    check("eol+vs err_count", 64'(err_count), 64'd3);
`ifdef VGA_CAPTURE_CHECKSUM_EN
    check("frame_sum", 64'(frame_sum), 64'd496);
`endif

    // Reset at row 1, column 3
    for (int c = 0; c < H; c++) cyc(0, 1, 0, pix(0, c, 0), 0);
    cyc(0, 0, 1, 24'h0, 0); cyc(0, 0, 0, 24'h0, 0);
    for (int c = 0; c < 3; c++) cyc(0, 1, 0, pix(0, c, 1), 0);
    cyc(0, 1, 0, pix(0, 3, 1), 1);
    check("mid-reset wr_en", 64'(wr_en), 64'd0);
    check("mid-reset wr_x", 64'(wr_x), 64'd0);
    check("mid-reset wr_data", 64'(wr_data), 64'd0);
    check("mid-reset err_count", 64'(err_count), 64'd0);
    check("mid-reset frame_count", 64'(frame_count), 64'd0);
    clr();
    for (int c = 4; c < H; c++) cyc(0, 1, 0, pix(0, c, 1), 0);
    cyc(0, 0, 1, 24'h0, 0); cyc(0, 0, 0, 24'h0, 0);
    rows(2, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("post-reset writes before vs", 64'(n_wr), 64'd0);
    check("post-reset frame_done", 64'(n_done), 64'd0);
    rows(V, -1, 0, 0, 0); vs_pulse(); idle(2);
    check("post-reset writes", 64'(n_wr), 64'd32);
    check("post-reset frame_count", 64'(frame_count), 64'd1);
    check("post-reset locked", 64'(locked), 64'd1);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
